// File: rtl/fmul_pkg.sv
// Shared state encoding, operand-class type and sizing helpers for the
// iterative FP multiplier front stage.
package fmul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } fmul_state_e;

   typedef struct packed {
      logic is_zero;
      logic is_den;
      logic is_inf;
      logic is_nan;
   } fmul_class_t;

   function automatic int mant_w(input int frac_w);
      return frac_w + 1;
   endfunction

   function automatic int ncyc(input int mw, input int bpc);
      return (mw + bpc - 1) / bpc;
   endfunction

   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fmul_classify.sv
// Combinational operand classifier: zero/denormal/inf/NaN plus the mantissa
// with hidden bit. FMUL_DENORM_EN keeps denormals; otherwise exp==0 flushes to zero.
module fmul_classify
   import fmul_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic [EXP_W+FRAC_W:0] op_i,
   output fmul_class_t           cls_o,
   output logic [FRAC_W:0]       mant_o
);

   logic [EXP_W-1:0]  e;
   logic [FRAC_W-1:0] f;
   logic              e_zero, e_ones, f_zero;

   assign e      = op_i[EXP_W+FRAC_W-1:FRAC_W];
   assign f      = op_i[FRAC_W-1:0];
   assign e_zero = (e == '0);
   assign e_ones = &e;
   assign f_zero = (f == '0);

   always_comb begin
      cls_o        = '0;
      mant_o       = {~e_zero, f};
      cls_o.is_inf = e_ones & f_zero;
      cls_o.is_nan = e_ones & ~f_zero;
`ifdef FMUL_DENORM_EN
      cls_o.is_zero = e_zero & f_zero;
      cls_o.is_den  = e_zero & ~f_zero;
`else
      cls_o.is_zero = e_zero;
`endif
   end

endmodule

// File: rtl/fmul_iter_mul.sv
// Iterative FP multiply front stage: classify, sign/exponent/special fraction,
// and a BPC-bits-per-cycle shift-add mantissa product. Honors FMUL_DENORM_EN.
module fmul_iter_mul
   import fmul_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int BPC    = 4
) (
   input  logic                    clk,
   input  logic                    clrn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W+FRAC_W:0]   a,
   input  logic [EXP_W+FRAC_W:0]   b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sign,
   output logic [EXP_W+1:0]        exp,
   output logic                    inf_nan,
   output logic [FRAC_W-1:0]       inf_nan_frac,
   output logic [2*FRAC_W+1:0]     prod,
   output logic                    busy
);

   localparam int MANT_W = mant_w(FRAC_W);
   localparam int PW     = 2 * MANT_W;
   localparam int NCYC   = ncyc(MANT_W, BPC);
   localparam int CNT_W  = $clog2(NCYC + 1);
   localparam int SB     = EXP_W + FRAC_W;
   localparam logic [EXP_W+1:0]  BIAS = (EXP_W + 2)'(bias(EXP_W));
   localparam logic [FRAC_W-1:0] QNAN = {1'b1, {(FRAC_W - 1){1'b0}}};

   fmul_class_t       ca, cb;
   logic [MANT_W-1:0] ma, mb;

   fmul_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (.op_i(a), .cls_o(ca), .mant_o(ma));
   fmul_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (.op_i(b), .cls_o(cb), .mant_o(mb));

   fmul_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [MANT_W-1:0] mplier_q, mplier_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic              sign_q, sign_d;
   logic [EXP_W+1:0]  exp_q, exp_d;
   logic              inf_nan_q, inf_nan_d;
   logic [FRAC_W-1:0] frac_q, frac_d;

   logic              any_nan, any_inf, any_zero, special;
   logic              ea_z, eb_z;
   logic [FRAC_W-1:0] sp_frac;
   logic [EXP_W+1:0]  exp_calc;
   logic [PW-1:0]     pp;

   // exp field is zero exactly when the operand is a zero or a denormal
   assign ea_z     = ca.is_zero | ca.is_den;
   assign eb_z     = cb.is_zero | cb.is_den;
   assign any_nan  = ca.is_nan | cb.is_nan;
   assign any_inf  = ca.is_inf | cb.is_inf;
   assign any_zero = ca.is_zero | cb.is_zero;
   assign special  = any_nan | any_inf | any_zero;
   assign exp_calc = {2'b00, a[SB-1:FRAC_W]} + {2'b00, b[SB-1:FRAC_W]} - BIAS
                   + {{(EXP_W + 1){1'b0}}, ea_z} + {{(EXP_W + 1){1'b0}}, eb_z};
   assign pp       = mcand_q * PW'(mplier_q[BPC-1:0]);

   always_comb begin
      if (ca.is_nan)              sp_frac = a[FRAC_W-1:0] | QNAN;
      else if (cb.is_nan)         sp_frac = b[FRAC_W-1:0] | QNAN;
      else if (any_inf && any_zero) sp_frac = QNAN;
      else                        sp_frac = '0;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      prod_d    = prod_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      inf_nan_d = inf_nan_q;
      frac_d    = frac_q;
      unique case (state_q)
         IDLE: if (in_valid) begin
            sign_d    = a[SB] ^ b[SB];
            inf_nan_d = any_nan | any_inf;
            exp_d     = (any_zero && !(any_nan || any_inf)) ? '0 : exp_calc;
            frac_d    = sp_frac;
            prod_d    = '0;
            cnt_d     = '0;
            mcand_d   = PW'(ma);
            mplier_d  = mb;
            state_d   = special ? DONE : MUL;
         end
         MUL: begin
            // mcand is pre-shifted so each partial product lands at BPC*cnt
            prod_d   = prod_q + pp;
            mcand_d  = mcand_q << BPC;
            mplier_d = mplier_q >> BPC;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NCYC - 1)) state_d = DONE;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         prod_q    <= '0;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         inf_nan_q <= 1'b0;
         frac_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         prod_q    <= prod_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         inf_nan_q <= inf_nan_d;
         frac_q    <= frac_d;
      end
   end

   assign in_ready     = (state_q == IDLE);
   assign out_valid    = (state_q == DONE);
   assign busy         = (state_q != IDLE);
   assign sign         = sign_q;
   assign exp          = exp_q;
   assign inf_nan      = inf_nan_q;
   assign inf_nan_frac = frac_q;
   assign prod         = prod_q;

endmodule

// File: tb/tb_fmul_iter_mul.sv
// Bench for fmul_iter_mul (FP32, BPC=4): directed cases plus randomized operands
// against an arithmetic reference model; follows FMUL_DENORM_EN if defined.
module tb_fmul_iter_mul;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int BPC    = 4;
   localparam int NCYC   = 6;
`ifdef FMUL_DENORM_EN
   localparam bit DEN = 1'b1;
`else
   localparam bit DEN = 1'b0;
`endif

   typedef struct {
      logic        s;
      logic [9:0]  e;
      logic        inan;
      logic [22:0] fr;
      logic [47:0] p;
      int          lat;
   } ref_t;

   logic        clk = 1'b0, clrn = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        in_ready, out_valid, sign, inf_nan, busy;
   logic [9:0]  exp_o;
   logic [22:0] frac_o;
   logic [47:0] prod_o;
   int          n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   fmul_iter_mul #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .BPC(BPC)) dut (
      .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .sign(sign), .exp(exp_o), .inf_nan(inf_nan), .inf_nan_frac(frac_o),
      .prod(prod_o), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   function automatic ref_t model(input logic [31:0] x, input logic [31:0] y);
      ref_t   r;
      int     ex, ey, e;
      longint fx, fy, mx, my;
      bit     xn, xi, xz, yn, yi, yz;
      ex = int'(x[30:23]); ey = int'(y[30:23]);
      fx = longint'(x[22:0]); fy = longint'(y[22:0]);
      xn = (ex == 255) && (fx != 0); xi = (ex == 255) && (fx == 0);
      yn = (ey == 255) && (fy != 0); yi = (ey == 255) && (fy == 0);
      xz = (ex == 0) && (fx == 0 || !DEN);
      yz = (ey == 0) && (fy == 0 || !DEN);
      r.s = x[31] ^ y[31];
      r.e = '0; r.fr = '0; r.p = '0; r.inan = 1'b0; r.lat = 1;
      if (xn || yn) begin
         r.inan = 1'b1;
         r.fr   = xn ? (x[22:0] | 23'h400000) : (y[22:0] | 23'h400000);
      end else if (xi || yi) begin
         r.inan = 1'b1;
         r.fr   = (xz || yz) ? 23'h400000 : 23'h0;
      end else if (!(xz || yz)) begin
         mx    = (ex == 0) ? fx : fx + (64'd1 << 23);
         my    = (ey == 0) ? fy : fy + (64'd1 << 23);
         r.p   = 48'(mx * my);
         e     = ex + ey - 127 + int'(ex == 0) + int'(ey == 0);
         r.e   = 10'(e);
         r.lat = NCYC + 1;
      end
      return r;
   endfunction

   function automatic logic [31:0] rnd_op();
      int          k;
      logic [31:0] v;
      k = $urandom_range(0, 9);
      v = $urandom();
      case (k)
         0: v[30:0]  = '0;
         1: v[30:23] = 8'h00;
         2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
         3: v[30:23] = 8'hFF;
         4: v[30:23] = 8'($urandom_range(1, 10));
         5: v[30:23] = 8'($urandom_range(245, 254));
         default: ;
      endcase
      return v;
   endfunction

   task automatic check_out(input ref_t r);
      chk("out_valid", out_valid, 1);
      chk("sign", sign, r.s);
      chk("inf_nan", inf_nan, r.inan);
      chk("prod", prod_o, r.p);
      if (r.inan) chk("inf_nan_frac", frac_o, r.fr);
      else        chk("exp", exp_o, r.e);
   endtask

   task automatic accept(input logic [31:0] ta, input logic [31:0] tb_);
      int w;
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 100) begin @(negedge clk); w++; end
      chk("in_ready_idle", in_ready, 1);
      a = ta; b = tb_; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom(); b = $urandom();
   endtask

   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input int stall);
      ref_t r;
      int   lat;
      r = model(ta, tb_);
      accept(ta, tb_);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      chk("latency", lat, r.lat);
      for (int i = 0; i <= stall; i++) begin
         check_out(r);
         chk("in_ready_done", in_ready, 0);
         chk("busy_done", busy, 1);
         if (i == stall) out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("out_valid_after_hs", out_valid, 0);
      chk("in_ready_after_hs", in_ready, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 clrn = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_prod", prod_o, 0);
      chk("rst_exp", exp_o, 0);
      chk("rst_inf_nan", inf_nan, 0);
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);

      run_op(32'h3FC00000, 32'h40000000, 0);
      run_op(32'h7F800000, 32'h00000000, 0);
      run_op(32'h7FA00001, 32'h3F800000, 0);
      run_op(32'h3FC00000, 32'h40000000, 5);

      // reset in the middle of a multiply discards it
      accept(32'h3FC00000, 32'h40000000);
      repeat (3) @(negedge clk);
      chk("busy_mul", busy, 1);
      #2 clrn = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_sign", sign, 0);
      chk("midrst_exp", exp_o, 0);
      chk("midrst_inf_nan", inf_nan, 0);
      chk("midrst_frac", frac_o, 0);
      chk("midrst_prod", prod_o, 0);
      @(negedge clk);
      clrn = 1'b1;
      run_op(32'hBFC00000, 32'h40400000, 1);

      run_op(32'h00000001, 32'h3F800000, 0);
      run_op(32'h00800000, 32'h00800000, 0);
      run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 0);

      for (int i = 0; i < 60; i++) run_op(rnd_op(), rnd_op(), $urandom_range(0, 3));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
